// File: rtl/ntt_stage_sequencer.sv
// rtl/ntt_stage_sequencer.sv - stage/beat scheduler for the NTT butterfly array
//
// Walks every NTT stage: one operand-read beat per unheld cycle, a twiddle ROM
// index per beat, and a fixed-latency delay line that turns each issue into
// exactly one write-back strobe. A stage drains completely before the next
// one starts, so reads of stage s+1 never see rows still being written by s.

module ntt_stage_sequencer #(
   parameter int STAGES     = 10,
   parameter int BEATS      = 16,
   parameter int BF_LATENCY = 8,
   parameter int BEAT_W     = 4,
   parameter int STAGE_W    = 4,
   parameter int TW_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               hold,
   output logic               busy,
   output logic               done,
   output logic               issue_valid,
   output logic [STAGE_W-1:0] issue_stage,
   output logic [BEAT_W-1:0]  issue_beat,
   output logic [TW_W-1:0]    tw_index,
   output logic               wb_valid,
   output logic [STAGE_W-1:0] wb_stage,
   output logic [BEAT_W-1:0]  wb_beat
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   logic [STAGE_W-1:0] stage_q;
   logic [BEAT_W-1:0]  beat_q;
   logic [TW_W-1:0]    tw_q;

   // Write-back delay line; index 0 is the newest entry, BF_LATENCY-1 the tail.
   logic [BF_LATENCY-1:0]              pipe_v;
   logic [BF_LATENCY-1:0][STAGE_W-1:0] pipe_s;
   logic [BF_LATENCY-1:0][BEAT_W-1:0]  pipe_b;

   logic last_beat;
   logic last_stage;
   logic drain_hit;

   assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
   assign last_stage = (stage_q == STAGE_W'(STAGES - 1));

   // The stage is finished once its final row is being written back.
   assign drain_hit  = wb_valid && (wb_beat == BEAT_W'(BEATS - 1)) && (wb_stage == stage_q);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode; issue_valid is the only output that follows hold combinationally.
   always_comb begin
      state_nx    = state;
      issue_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue_valid = !hold;
            if (!hold && last_beat) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_hit) begin
               state_nx = last_stage ? S_DONE : S_ISSUE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Stage, beat and twiddle counters. The twiddle index only ever increments:
   // after the last beat of stage s it lands exactly on (s+1)*BEATS.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q <= '0;
         beat_q  <= '0;
         tw_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  stage_q <= '0;
                  beat_q  <= '0;
                  tw_q    <= '0;
               end
            end
            S_ISSUE: begin
               if (!hold && !last_beat) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  tw_q   <= tw_q + TW_W'(1);
               end
            end
            S_DRAIN: begin
               if (drain_hit) begin
                  if (!last_stage) begin
                     stage_q <= stage_q + STAGE_W'(1);
                     beat_q  <= '0;
                     tw_q    <= tw_q + TW_W'(1);
                  end else begin
                     stage_q <= '0;
                     beat_q  <= '0;
                     tw_q    <= '0;
                  end
               end
            end
            default: begin
               stage_q <= stage_q;
            end
         endcase
      end
   end

   // Delay line shifts every cycle, independent of state and hold; a reset
   // drops every in-flight entry so no stale write-back can follow it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_v <= '0;
         pipe_s <= '0;
         pipe_b <= '0;
      end else begin
         pipe_v[0] <= issue_valid;
         pipe_s[0] <= issue_valid ? stage_q : '0;
         pipe_b[0] <= issue_valid ? beat_q : '0;
         for (int i = 1; i < BF_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_s[i] <= pipe_s[i-1];
            pipe_b[i] <= pipe_b[i-1];
         end
      end
   end

   assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
   assign done        = (state == S_DONE);
   assign issue_stage = stage_q;
   assign issue_beat  = beat_q;
   assign tw_index    = tw_q;
   assign wb_valid    = pipe_v[BF_LATENCY-1];
   assign wb_stage    = pipe_s[BF_LATENCY-1];
   assign wb_beat     = pipe_b[BF_LATENCY-1];

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb/tb_ntt_stage_sequencer.sv - self-checking bench for ntt_stage_sequencer

module tb_ntt_stage_sequencer;

   localparam int NC = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, hold, start2, hold2;

   logic       m_busy, m_done, m_iv, m_wv;
   logic [3:0] m_is, m_ib, m_ws, m_wb;
   logic [7:0] m_tw;

   logic       v_busy, v_done, v_iv, v_wv;
   logic [1:0] v_is, v_ib, v_ws, v_wb;
   logic [3:0] v_tw;

   ntt_stage_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold),
      .busy(m_busy), .done(m_done), .issue_valid(m_iv),
      .issue_stage(m_is), .issue_beat(m_ib), .tw_index(m_tw),
      .wb_valid(m_wv), .wb_stage(m_ws), .wb_beat(m_wb)
   );

   ntt_stage_sequencer #(
      .STAGES(3), .BEATS(4), .BF_LATENCY(2), .BEAT_W(2), .STAGE_W(2), .TW_W(4)
   ) dut_small (
      .clk(clk), .rst(rst), .start(start2), .hold(hold2),
      .busy(v_busy), .done(v_done), .issue_valid(v_iv),
      .issue_stage(v_is), .issue_beat(v_ib), .tw_index(v_tw),
      .wb_valid(v_wv), .wb_stage(v_ws), .wb_beat(v_wb)
   );

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   logic [31:0] o_busy, o_done, o_iv, o_wv, o_is, o_ib, o_tw, o_ws, o_wb;

   // Observation mux: which instance the check loop is looking at.
   always_comb begin
      o_busy = (sel == 1) ? 32'(v_busy) : 32'(m_busy);
      o_done = (sel == 1) ? 32'(v_done) : 32'(m_done);
      o_iv   = (sel == 1) ? 32'(v_iv)   : 32'(m_iv);
      o_wv   = (sel == 1) ? 32'(v_wv)   : 32'(m_wv);
      o_is   = (sel == 1) ? 32'(v_is)   : 32'(m_is);
      o_ib   = (sel == 1) ? 32'(v_ib)   : 32'(m_ib);
      o_tw   = (sel == 1) ? 32'(v_tw)   : 32'(m_tw);
      o_ws   = (sel == 1) ? 32'(v_ws)   : 32'(m_ws);
      o_wb   = (sel == 1) ? 32'(v_wb)   : 32'(m_wb);
   end

   // Reference model parameters and per-cycle expectations.
   int ms, mb, ml;
   bit h [NC];
   bit st[NC];
   bit e_iv[NC], e_wv[NC], e_busy[NC], e_done[NC];
   int e_is[NC], e_ib[NC], e_tw[NC], e_ws[NC], e_wb[NC];
   int first_done;

   // Observed-event trackers filled by the check loop.
   int n_iss, n_wb, n_busy, done_cyc, next_iss, b2_cyc, s0_last_wb, s1_first, s1_tw, max_tw;

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One transform launched with its first issue opportunity in cycle t.
   // Stage s issues its beats on unheld cycles; each write-back lands ml
   // cycles after its issue; the next stage opens right after the last one.
   task automatic build_run(input int t, output int d);
      int c;
      c = t;
      for (int s = 0; s < ms; s++) begin
         int first_c, last_c, b;
         first_c = c;
         last_c  = c;
         b       = 0;
         while (b < mb && c < NC - ml - 2) begin
            if (!h[c]) begin
               e_iv[c] = 1'b1; e_is[c] = s; e_ib[c] = b; e_tw[c] = s * mb + b;
               e_wv[c + ml] = 1'b1; e_ws[c + ml] = s; e_wb[c + ml] = b;
               last_c = c;
               b++;
            end
            c++;
         end
         for (int k = first_c; k <= last_c + ml; k++) e_busy[k] = 1'b1;
         c = last_c + ml + 1;
      end
      if (c < NC) e_done[c] = 1'b1;
      d = c;
   endtask

   // Starts are honoured only while idle; a run is idle again the cycle after done.
   task automatic build_model();
      int idle_from, d;
      for (int k = 0; k < NC; k++) begin
         e_iv[k] = 0; e_wv[k] = 0; e_busy[k] = 0; e_done[k] = 0;
         e_is[k] = 0; e_ib[k] = 0; e_tw[k] = 0; e_ws[k] = 0; e_wb[k] = 0;
      end
      idle_from  = 0;
      first_done = -1;
      for (int k = 0; k < NC - 1; k++) begin
         if (st[k] && k >= idle_from) begin
            build_run(k + 1, d);
            if (first_done < 0) first_done = d;
            idle_from = d + 1;
         end
      end
   endtask

   task automatic clear_stim();
      for (int k = 0; k < NC; k++) begin
         st[k] = 1'b0;
         h[k]  = 1'b0;
      end
   endtask

   // Cycle k is the cycle after the k-th edge seen here; inputs are driven
   // just after the edge and outputs sampled just before the next one.
   task automatic check_cycles(input int ncyc);
      n_iss = 0; n_wb = 0; n_busy = 0; done_cyc = -1; next_iss = -1;
      b2_cyc = -1; s0_last_wb = -1; s1_first = -1; s1_tw = -1; max_tw = -1;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         start  = (sel == 0) ? st[k] : 1'b0;
         hold   = (sel == 0) ? h[k]  : 1'b0;
         start2 = (sel == 1) ? st[k] : 1'b0;
         hold2  = (sel == 1) ? h[k]  : 1'b0;
         #3;
         chk("busy", k, o_busy, 32'(e_busy[k]));
         chk("done", k, o_done, 32'(e_done[k]));
         chk("issue_valid", k, o_iv, 32'(e_iv[k]));
         chk("wb_valid", k, o_wv, 32'(e_wv[k]));
         if (e_iv[k]) begin
            chk("issue_stage", k, o_is, 32'(e_is[k]));
            chk("issue_beat", k, o_ib, 32'(e_ib[k]));
            chk("tw_index", k, o_tw, 32'(e_tw[k]));
         end
         if (e_wv[k]) begin
            chk("wb_stage", k, o_ws, 32'(e_ws[k]));
            chk("wb_beat", k, o_wb, 32'(e_wb[k]));
         end
         if (done_cyc < 0) begin
            if (o_iv === 32'd1) n_iss++;
            if (o_wv === 32'd1) n_wb++;
            if (o_busy === 32'd1) n_busy++;
            if (o_iv === 32'd1 && o_is == 0 && o_ib == 2 && b2_cyc < 0) b2_cyc = k;
            if (o_wv === 32'd1 && o_ws == 0 && o_wb == 32'(mb - 1)) s0_last_wb = k;
            if (o_iv === 32'd1 && o_is == 1 && s1_first < 0) begin
               s1_first = k;
               s1_tw    = int'(o_tw);
            end
            if (o_iv === 32'd1 && int'(o_tw) > max_tw) max_tw = int'(o_tw);
            if (o_done === 32'd1) done_cyc = k;
         end else if (o_iv === 32'd1 && next_iss < 0) begin
            next_iss = k;
         end
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; hold = 1'b0; start2 = 1'b0; hold2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 0, 32'(m_busy), 32'd0);
      chk("rst_done", 0, 32'(m_done), 32'd0);
      chk("rst_iv", 0, 32'(m_iv), 32'd0);
      chk("rst_wv", 0, 32'(m_wv), 32'd0);
      chk("rst_tw", 0, 32'(m_tw), 32'd0);
      chk("rst_small_busy", 0, 32'(v_busy), 32'd0);
      rst = 1'b1;

      // Full run with no hold; starts at 50 and 241 ignored, start at 242 relaunches.
      sel = 0; ms = 10; mb = 16; ml = 8;
      clear_stim();
      st[0] = 1'b1; st[50] = 1'b1; st[241] = 1'b1; st[242] = 1'b1;
      build_model();
      check_cycles(342);
      chk("full_issue_count", 0, 32'(n_iss), 32'd160);
      chk("full_wb_count", 0, 32'(n_wb), 32'd160);
      chk("full_busy_cycles", 0, 32'(n_busy), 32'd240);
      chk("full_done_cycle", 0, 32'(done_cyc), 32'd241);
      chk("relaunch_first_issue", 0, 32'(next_iss), 32'd243);
      chk("stage1_first_issue", 0, 32'(s1_first), 32'd25);
      chk("stage1_first_tw", 0, 32'(s1_tw), 32'd16);

      // Asynchronous reset in the middle of stage 4 of the relaunched run.
      @(posedge clk);
      #1;
      start = 1'b0; hold = 1'b0;
      chk("pre_reset_issue_valid", 342, 32'(m_iv), 32'(e_iv[342]));
      rst = 1'b0;
      #1;
      chk("arst_busy", 342, 32'(m_busy), 32'd0);
      chk("arst_done", 342, 32'(m_done), 32'd0);
      chk("arst_iv", 342, 32'(m_iv), 32'd0);
      chk("arst_wv", 342, 32'(m_wv), 32'd0);
      chk("arst_is", 342, 32'(m_is), 32'd0);
      chk("arst_ib", 342, 32'(m_ib), 32'd0);
      chk("arst_tw", 342, 32'(m_tw), 32'd0);
      chk("arst_ws", 342, 32'(m_ws), 32'd0);
      chk("arst_wb", 342, 32'(m_wb), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      clear_stim();
      build_model();
      check_cycles(30);

      // Restart after reset with random hold and stray start pulses while busy.
      clear_stim();
      st[0] = 1'b1;
      for (int k = 1; k < 200; k++) st[k] = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NC; k++) h[k] = ($urandom_range(0, 3) == 0);
      build_model();
      check_cycles(first_done + 3);
      chk("rand_issue_count", 0, 32'(n_iss), 32'd160);
      chk("rand_wb_count", 0, 32'(n_wb), 32'd160);
      chk("rand_done_cycle", 0, 32'(done_cyc), 32'(first_done));

      // hold in cycles 3..5 of stage 0.
      clear_stim();
      st[0] = 1'b1; h[3] = 1'b1; h[4] = 1'b1; h[5] = 1'b1;
      build_model();
      check_cycles(247);
      chk("hold_beat2_cycle", 0, 32'(b2_cyc), 32'd6);
      chk("hold_s0_last_wb", 0, 32'(s0_last_wb), 32'd27);
      chk("hold_done_cycle", 0, 32'(done_cyc), 32'd244);

      // Small variant: 3 stages, 4 beats, latency 2.
      sel = 1; ms = 3; mb = 4; ml = 2;
      clear_stim();
      st[0] = 1'b1;
      build_model();
      check_cycles(24);
      chk("small_done_cycle", 0, 32'(done_cyc), 32'd19);
      chk("small_max_tw", 0, 32'(max_tw), 32'd11);
      chk("small_issue_count", 0, 32'(n_iss), 32'd12);
      chk("small_wb_count", 0, 32'(n_wb), 32'd12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
